// File: rtl/uio_arb_pkg.sv
// Shared types and parameter defaults for the uio pad-port arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_TURNAROUND = 1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uio_arb_rr.sv
// Two-way round-robin winner picker: a lone requester wins, a tie goes to
// whichever requester did not own the bus last.
module uio_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];
    end

endmodule

// File: rtl/uio_port_arbiter.sv
// Arbitrates two requesters onto the shared uio pad port, inserting bus-quiet
// turnaround cycles whenever the pad direction flips.
module uio_port_arbiter
    import uio_arb_pkg::*;
#(
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic [1:0] wr,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] grant,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       rid,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LP_LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [1:0] LP_LAST_TURN = 2'(TURNAROUND - 1);

    arb_state_e r_state, w_state_next;
    logic       r_owner, w_owner_next;
    logic       r_dir, w_dir_next;
    logic       r_last, w_last_next;
    logic [3:0] r_beat_cnt, w_beat_cnt_next;
    logic [1:0] r_turn_cnt, w_turn_cnt_next;
    logic [1:0] r_grant, w_grant_next;
    logic [7:0] r_rdata;
    logic       r_rvalid;
    logic       r_rid;

    logic       w_winner;
    logic       w_any_req;
    logic       w_beat;
    logic       w_wr_beat;
    logic       w_rd_beat;
    logic [7:0] w_wdata;

    uio_arb_rr u_rr (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_any_req)
    );

    // ena gates the beat so the pads release in the same cycle ena drops.
    assign w_beat    = ena & (r_state == ST_OWN) & req[r_owner];
    assign w_wr_beat = w_beat & r_dir;
    assign w_rd_beat = w_beat & ~r_dir;
    assign w_wdata   = r_owner ? wdata1 : wdata0;

    assign uio_oe  = w_wr_beat ? 8'hFF : 8'h00;
    assign uio_out = w_wr_beat ? w_wdata : 8'h00;
    assign grant   = r_grant;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign rid     = r_rid;

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_dir_next      = r_dir;
        w_last_next     = r_last;
        w_beat_cnt_next = r_beat_cnt;
        w_turn_cnt_next = r_turn_cnt;

        if (!ena) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        w_owner_next = w_winner;
                        if (wr[w_winner] == r_dir) begin
                            w_state_next    = ST_OWN;
                            w_beat_cnt_next = 4'd0;
                        end else begin
                            w_state_next    = ST_TURN;
                            w_dir_next      = wr[w_winner];
                            w_turn_cnt_next = 2'd0;
                        end
                    end
                end
                ST_TURN: begin
                    if (r_turn_cnt == LP_LAST_TURN) begin
                        w_state_next    = ST_OWN;
                        w_beat_cnt_next = 4'd0;
                    end else begin
                        w_turn_cnt_next = r_turn_cnt + 2'd1;
                    end
                end
                ST_OWN: begin
                    if (w_beat) begin
                        w_beat_cnt_next = r_beat_cnt + 4'd1;
                    end
                    // A cycle without a beat releases the bus, as does the final beat.
                    if (!w_beat || (r_beat_cnt == LP_LAST_BEAT)) begin
                        w_state_next = ST_IDLE;
                        w_last_next  = r_owner;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        w_grant_next = (w_state_next == ST_OWN) ? onehot2(w_owner_next) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_dir      <= 1'b0;
            r_last     <= 1'b1;
            r_beat_cnt <= 4'd0;
            r_turn_cnt <= 2'd0;
            r_grant    <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_dir      <= w_dir_next;
            r_last     <= w_last_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_turn_cnt <= w_turn_cnt_next;
            r_grant    <= w_grant_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
            r_rid    <= 1'b0;
        end else begin
            r_rvalid <= w_rd_beat;
            if (w_rd_beat) begin
                r_rdata <= uio_in;
                r_rid   <= r_owner;
            end
        end
    end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Bench for uio_port_arbiter: scripted vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_uio_port_arbiter;

    localparam int P_MAXB = 4;
    localparam int P_TURN = 1;
    localparam int M_IDLE = 0;
    localparam int M_TURN = 1;
    localparam int M_OWN  = 2;
    localparam int NV     = 21;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [1:0] wr     = 2'b00;
    logic [7:0] wdata0 = 8'h00;
    logic [7:0] wdata1 = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [1:0] grant;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rid;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_state;
    int         m_owner;
    int         m_last;
    int         m_beats;
    int         m_tleft;
    int         m_txn;
    bit         m_dir;
    bit         m_rvalid;
    bit         m_rid;
    logic [7:0] m_rdata;

    typedef struct {
        bit         do_rst;
        bit         en;
        logic [1:0] rq;
        logic [1:0] w;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] ui;
        logic [1:0] g;
        logic [7:0] oe;
        logic [7:0] o;
        bit         rv;
        bit         ri;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    uio_port_arbiter #(
        .MAX_BURST  (P_MAXB),
        .TURNAROUND (P_TURN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .wr      (wr),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .grant   (grant),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rid     (rid),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_state  = M_IDLE;
        m_owner  = 0;
        m_last   = 1;
        m_beats  = 0;
        m_tleft  = 0;
        m_dir    = 1'b0;
        m_rvalid = 1'b0;
        m_rid    = 1'b0;
        m_rdata  = 8'h00;
    endtask

    // Called at each rising edge with the inputs that were presented that cycle.
    task automatic m_step();
        int w;
        bit beat;
        beat = ena && (m_state == M_OWN) && req[m_owner];
        m_rvalid = beat && !m_dir;
        if (m_rvalid) begin
            m_rdata = uio_in;
            m_rid   = (m_owner == 1);
        end
        if (!ena) begin
            m_state = M_IDLE;
            return;
        end
        case (m_state)
            M_IDLE: if (req != 2'b00) begin
                w = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
                m_owner = w;
                if (wr[w] == m_dir) begin
                    m_state = M_OWN;
                    m_beats = 0;
                end else begin
                    m_dir   = wr[w];
                    m_state = M_TURN;
                    m_tleft = P_TURN;
                end
                if (m_state == M_OWN) begin
                    m_txn++;
                    $display("txn %0d: owner=%0d dir=%0d", m_txn, m_owner, m_dir);
                end
            end
            M_TURN: begin
                m_tleft--;
                if (m_tleft == 0) begin
                    m_state = M_OWN;
                    m_beats = 0;
                    m_txn++;
                    $display("txn %0d: owner=%0d dir=%0d (after turnaround)", m_txn, m_owner, m_dir);
                end
            end
            default: begin
                if (beat) begin
                    m_beats++;
                    if (m_beats == P_MAXB) begin
                        m_state = M_IDLE;
                        m_last  = m_owner;
                    end
                end else begin
                    m_state = M_IDLE;
                    m_last  = m_owner;
                end
            end
        endcase
    endtask

    // Enters and leaves at a falling edge; reset is released with ena high.
    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b0;
        req    = 2'b00;
        wr     = 2'b00;
        uio_in = 8'h00;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    task automatic seq_drop_in_turn();
        do_reset();
        req = 2'b01; wr = 2'b01; wdata0 = 8'h81;
        @(negedge clk);
        req = 2'b00;
        #1;
        chk("dropturn.grant_turn", 8'(grant), 8'h00);
        chk("dropturn.oe_turn", uio_oe, 8'h00);
        @(negedge clk);
        #1;
        chk("dropturn.grant_own", 8'(grant), 8'h01);
        chk("dropturn.oe_own", uio_oe, 8'h00);
        @(negedge clk);
        #1;
        chk("dropturn.grant_rel", 8'(grant), 8'h00);
        $display("seq drop-in-turn done");
        @(negedge clk);
    endtask

    task automatic seq_burst_limit();
        int pulses = 0;
        int pulses_at_drop = -1;
        bit seen_grant = 1'b0;
        bit dropped = 1'b0;
        bit regrant = 1'b0;
        logic [7:0] prev_in = 8'h00;
        do_reset();
        req = 2'b01; wr = 2'b00;
        for (int c = 0; c < 12; c++) begin
            uio_in = 8'($urandom);
            #1;
            if (rvalid) begin
                pulses++;
                chk("burst.rdata", rdata, prev_in);
            end
            if (grant == 2'b01) begin
                if (dropped) regrant = 1'b1;
                else seen_grant = 1'b1;
            end else if (seen_grant && !dropped) begin
                dropped = 1'b1;
                pulses_at_drop = pulses;
            end
            prev_in = uio_in;
            @(negedge clk);
        end
        chk("burst.pulses", 8'(pulses_at_drop), 8'(P_MAXB));
        chk("burst.regrant", 8'(regrant), 8'h01);
        $display("seq burst-limit: %0d pulses before release", pulses_at_drop);
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic seq_write_then_read();
        int gap = 0;
        bit gap_done = 1'b0;
        bit saw_wr = 1'b0;
        bit saw_rd1 = 1'b0;
        do_reset();
        wdata0 = 8'h5A; wdata1 = 8'hC0; wr = 2'b01;
        for (int c = 0; c < 16; c++) begin
            req    = {~saw_rd1, (c < 4)};
            uio_in = 8'($urandom);
            #1;
            chk("xfer.no_double", 8'(grant == 2'b11), 8'h00);
            if (uio_oe == 8'hFF) begin
                saw_wr = 1'b1;
                gap = 0;
                chk("xfer.wdata", uio_out, 8'h5A);
            end else if (saw_wr && !gap_done) begin
                if (grant == 2'b10) gap_done = 1'b1;
                else gap++;
            end
            if (rvalid && rid) saw_rd1 = 1'b1;
            @(negedge clk);
        end
        chk("xfer.saw_write", 8'(saw_wr), 8'h01);
        chk("xfer.reader_granted", 8'(gap_done), 8'h01);
        chk("xfer.gap_ge_turn", 8'(gap >= P_TURN), 8'h01);
        chk("xfer.read_rid1", 8'(saw_rd1), 8'h01);
        $display("seq write-then-read: quiet gap %0d cycles", gap);
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic seq_reset_mid_burst();
        do_reset();
        req = 2'b01; wr = 2'b00; uio_in = 8'h00;
        @(negedge clk);
        uio_in = 8'hE7;
        @(negedge clk);
        uio_in = 8'h12;
        #1;
        chk("rstmid.pre_rvalid", 8'(rvalid), 8'h01);
        chk("rstmid.pre_rdata", rdata, 8'hE7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.grant", 8'(grant), 8'h00);
        chk("rstmid.rvalid", 8'(rvalid), 8'h00);
        chk("rstmid.rdata", rdata, 8'h00);
        chk("rstmid.rid", 8'(rid), 8'h00);
        chk("rstmid.oe", uio_oe, 8'h00);
        chk("rstmid.out", uio_out, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstmid.held_grant", 8'(grant), 8'h00);
        chk("rstmid.held_rvalid", 8'(rvalid), 8'h00);
        rst_n = 1'b1;
        req = 2'b11; wr = 2'b00;
        @(negedge clk);
        #1;
        chk("rstmid.first_favours0", 8'(grant), 8'h01);
        $display("seq reset-mid-burst done");
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b01, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b01, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 2'b00, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 2'b00, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 2'b11, 2'b00, 8'hEE, 8'hEE, 8'h11, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 2'b00, 8'hEE, 8'hEE, 8'h3C, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 2'b10, 2'b00, 8'hEE, 8'hEE, 8'h77, 2'b01, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C};
        tbl[9]  = '{1'b0, 1'b1, 2'b10, 2'b00, 8'hEE, 8'hEE, 8'h44, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C};
        tbl[10] = '{1'b0, 1'b1, 2'b10, 2'b00, 8'hEE, 8'hEE, 8'h5A, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 2'b00, 8'hEE, 8'hEE, 8'h00, 2'b10, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A};
        tbl[12] = '{1'b0, 1'b1, 2'b00, 2'b00, 8'hEE, 8'hEE, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h5A};
        tbl[13] = '{1'b1, 1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b01, 8'hFF, 8'hC3, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{1'b0, 1'b0, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[17] = '{1'b0, 1'b0, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[18] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[19] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b01, 8'hFF, 8'hC3, 1'b0, 1'b0, 8'h00};
        tbl[20] = '{1'b0, 1'b1, 2'b00, 2'b01, 8'hC3, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        m_txn = 0;

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].do_rst) do_reset();
            ena = tbl[i].en; req = tbl[i].rq; wr = tbl[i].w;
            wdata0 = tbl[i].d0; wdata1 = tbl[i].d1; uio_in = tbl[i].ui;
            #1;
            chk($sformatf("vec%0d.grant", i), 8'(grant), 8'(tbl[i].g));
            chk($sformatf("vec%0d.oe", i), uio_oe, tbl[i].oe);
            chk($sformatf("vec%0d.out", i), uio_out, tbl[i].o);
            chk($sformatf("vec%0d.rvalid", i), 8'(rvalid), 8'(tbl[i].rv));
            chk($sformatf("vec%0d.rid", i), 8'(rid), 8'(tbl[i].ri));
            chk($sformatf("vec%0d.rdata", i), rdata, tbl[i].rd);
            $display("vec %0d: ena=%b req=%b wr=%b grant=%b oe=%02h out=%02h rvalid=%b rid=%b rdata=%02h",
                     i, ena, req, wr, grant, uio_oe, uio_out, rvalid, rid, rdata);
            @(negedge clk);
        end

        seq_drop_in_turn();
        seq_burst_limit();
        seq_write_then_read();
        seq_reset_mid_burst();

        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [1:0] eg;
            logic [7:0] eoe;
            logic [7:0] eout;
            bit beat;
            ena    = ($urandom_range(0, 19) != 0);
            req    = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            wr     = 2'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            uio_in = 8'($urandom);
            #1;
            eg   = (m_state == M_OWN) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            beat = ena && (m_state == M_OWN) && req[m_owner];
            eoe  = (beat && m_dir) ? 8'hFF : 8'h00;
            eout = (beat && m_dir) ? ((m_owner == 1) ? wdata1 : wdata0) : 8'h00;
            chk("rand.grant", 8'(grant), 8'(eg));
            chk("rand.oe", uio_oe, eoe);
            chk("rand.out", uio_out, eout);
            chk("rand.rvalid", 8'(rvalid), 8'(m_rvalid));
            if (m_rvalid) begin
                chk("rand.rdata", rdata, m_rdata);
                chk("rand.rid", 8'(rid), 8'(m_rid));
            end
            @(posedge clk);
            m_step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uio_port_arbiter.md
UIO_PORT_ARBITER -- requirements
Module: uio_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum beats per grant (1..15).
REQ-002 SHALL have parameter TURNAROUND, default 1, meaning the bus-quiet cycles on a direction change (1..3).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  block enable; low forces release of the bus.
REQ-006 SHALL have port req  input  2  per-requester bus request, index 0/1.
REQ-007 SHALL have port wr  input  2  per-requester direction, 1 = drive uio, 0 = sample uio.
REQ-008 SHALL have ports wdata0 and wdata1  input  8 each  per-requester write data.
REQ-009 SHALL have port grant  output  2  registered one-hot ownership, at most one bit set.
REQ-010 SHALL have port rdata  output  8  registered sample of uio_in.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-012 SHALL have port rid  output  1  requester index that owns rdata.
REQ-013 SHALL have ports uio_in  input  8, uio_out  output  8 and uio_oe  output  8, the shared bidirectional pad port (oe 1 = output).

Function
REQ-014 SHALL implement FSM states IDLE, TURN and OWN, plus registers owner, dir_q (bus direction, 1 = drive), last (last owner), beat counter and turnaround counter.
REQ-015 In IDLE with ena=1 and any req bit set, SHALL select a winner: the single requester if only one requests, otherwise the requester not equal to last.
REQ-016 SHALL go IDLE->OWN when wr[winner]==dir_q, and otherwise IDLE->TURN with dir_q updated to wr[winner]; owner<=winner in both cases.
REQ-017 SHALL hold TURN for exactly TURNAROUND cycles with uio_oe=0 and grant=0, then enter OWN.
REQ-018 SHALL set grant[owner]=1 in OWN; req asserted in IDLE at edge N yields grant high after edge N+1 (no turn) or edge N+1+TURNAROUND.
REQ-019 A beat SHALL be any OWN cycle with req[owner]=1; each beat increments the beat counter, which clears on entry to OWN.
REQ-020 On a write beat, SHALL drive uio_oe=8'hFF and uio_out=wdata[owner] combinationally.
REQ-021 On a read beat, SHALL register rdata<=uio_in, rvalid<=1 and rid<=owner, so the response appears the cycle after the beat.
REQ-022 SHALL leave OWN->IDLE, setting last<=owner and grant<=0 at the same edge, when req[owner]=0 (no beat) or when the MAX_BURST-th beat completes.
REQ-023 Outside write beats, SHALL drive uio_oe=0 and uio_out=0; rvalid SHALL be 0 except as set by REQ-021.
REQ-024 ena=0 in any state SHALL force IDLE at the next edge with grant=0 and uio_oe=0 immediately (combinational gate); dir_q and last SHALL be kept.
REQ-025 A requester dropping req during TURN SHALL still reach OWN, then release on its first OWN cycle with zero beats.
REQ-026 Changes to wr[owner] during OWN SHALL be ignored; direction is fixed per grant by dir_q.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, grant=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, rid=0, dir_q=0, last=1 and all counters 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further beats; the first arbitration after reset SHALL favour requester 0.

Structure
REQ-029 SHALL take the state enum and the MAX_BURST/TURNAROUND defaults from shared package uio_arb_pkg.
REQ-030 SHALL contain one sub-module, uio_arb_rr, a 2-way round-robin winner picker taking req and last; all else stays in the top.

Verification
REQ-031 Reset then req=01, wr=01, wdata0=8'hA5, req held 2 cycles -> TURN 1 cycle, then uio_oe=FF and uio_out=A5 for 2 beats, then grant=00.
REQ-032 req=11 from IDLE after reset, both wr=0 -> grant=01 first; after release grant=10; rvalid pulses carry rid 0 then 1.
REQ-033 req0 held high, wr=0, MAX_BURST=4 -> exactly 4 rvalid pulses, grant drops, then regranted; rdata equals uio_in of each beat cycle.
REQ-034 Owner 0 writing then owner 1 reading -> between them uio_oe=0 for >=TURNAROUND cycles; grant never 11.
REQ-035 ena low mid-write burst -> uio_oe=0 the same cycle, grant=00 next edge; rst_n low mid-burst -> all outputs 0 asynchronously.
